// File: rtl/otp_pkg.sv
// Shared one-time-pad datapath sizing and the collector state encoding.
// Used by the shifter/collector pair so both sides agree on slice geometry.
package otp_pkg;
  localparam int KEY_SIZE   = 16;
  localparam int MSG_SIZE   = 240;
  localparam int NUM_CHUNKS = MSG_SIZE / KEY_SIZE;
  localparam int CNT_W      = $clog2(NUM_CHUNKS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;
endpackage

// File: rtl/otp_xor_collector_if.sv
// Slice stream in, ciphertext/status out; master drives, slave is the collector.
interface otp_xor_collector_if;
  import otp_pkg::*;

  logic                start;
  logic                chunk_valid;
  logic [KEY_SIZE-1:0] chunk_in;
  logic [KEY_SIZE-1:0] key_in;
  logic                busy;
  logic                done;
  logic                slice_valid;
  logic [KEY_SIZE-1:0] slice_out;
  logic [CNT_W-1:0]    chunk_count;
  logic [MSG_SIZE-1:0] cipher_out;

  modport master (
    output start, chunk_valid, chunk_in, key_in,
    input  busy, done, slice_valid, slice_out, chunk_count, cipher_out
  );

  modport slave (
    input  start, chunk_valid, chunk_in, key_in,
    output busy, done, slice_valid, slice_out, chunk_count, cipher_out
  );
endinterface

// File: rtl/otp_xor_slice.sv
// Registered XOR of one slice with its key; one-cycle latency, no backpressure.
// Data holds between strobes so the output is stable for slow consumers.
module otp_xor_slice
  import otp_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_vld,
  input  logic [KEY_SIZE-1:0] i_dat,
  input  logic [KEY_SIZE-1:0] i_key,
  output logic                o_vld,
  output logic [KEY_SIZE-1:0] o_dat
);
  logic                r_vld;
  logic [KEY_SIZE-1:0] r_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else begin
      r_vld <= i_vld;
      if (i_vld) r_dat <= i_dat ^ i_key;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;
endmodule

// File: rtl/otp_xor_collector.sv
// Absorbs NUM_CHUNKS XOR-encrypted slices MSB-first into the ciphertext; 1-cycle
// slice latency, no backpressure (bubbles allowed), start aborts and rearms.
module otp_xor_collector
  import otp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  otp_xor_collector_if.slave bus
);
  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic [CNT_W-1:0]    r_count;
  logic [MSG_SIZE-1:0] r_cipher;

  logic                w_absorb;
  logic                w_last;
  logic [KEY_SIZE-1:0] w_xor;

  // start outranks a coincident valid slice, which is dropped
  assign w_absorb = (r_state == COLLECT) && bus.chunk_valid && !bus.start;
  assign w_last   = (r_count == CNT_W'(NUM_CHUNKS - 1));
  assign w_xor    = bus.chunk_in ^ bus.key_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_count  <= '0;
      r_cipher <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.start) begin
        r_state  <= COLLECT;
        r_busy   <= 1'b1;
        r_count  <= '0;
        r_cipher <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_busy <= 1'b0;
          end
          COLLECT: begin
            if (w_absorb) begin
              r_cipher <= {r_cipher[MSG_SIZE-KEY_SIZE-1:0], w_xor};
              r_count  <= r_count + 1'b1;
              if (w_last) begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  otp_xor_slice u_slice (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (w_absorb),
    .i_dat (bus.chunk_in),
    .i_key (bus.key_in),
    .o_vld (bus.slice_valid),
    .o_dat (bus.slice_out)
  );

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.chunk_count = r_count;
  assign bus.cipher_out  = r_cipher;
endmodule

// File: tb/tb_otp_xor_collector.sv
// Directed bench for otp_xor_collector: hand-computed vectors plus a shift model.
module tb_otp_xor_collector;
  import otp_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [MSG_SIZE-1:0] exp_cipher;
  int                  exp_cnt;
  logic [MSG_SIZE-1:0] held_cipher;

  otp_xor_collector_if bus ();

  otp_xor_collector dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [MSG_SIZE-1:0] obs,
                     input logic [MSG_SIZE-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    exp_cipher = '0;
    exp_cnt    = 0;
    chk("start_busy", MSG_SIZE'(bus.busy), 1);
    chk("start_cnt", MSG_SIZE'(bus.chunk_count), 0);
    chk("start_cipher", bus.cipher_out, '0);
  endtask

  task automatic feed(input logic [KEY_SIZE-1:0] c, input logic [KEY_SIZE-1:0] k);
    logic [KEY_SIZE-1:0] x;
    x = c ^ k;
    bus.chunk_valid = 1'b1;
    bus.chunk_in    = c;
    bus.key_in      = k;
    step();
    bus.chunk_valid = 1'b0;
    exp_cipher = {exp_cipher[MSG_SIZE-KEY_SIZE-1:0], x};
    exp_cnt++;
    chk("slice_valid", MSG_SIZE'(bus.slice_valid), 1);
    chk("slice_out", MSG_SIZE'(bus.slice_out), MSG_SIZE'(x));
    chk("chunk_count", MSG_SIZE'(bus.chunk_count), MSG_SIZE'(exp_cnt));
    chk("done", MSG_SIZE'(bus.done), MSG_SIZE'(exp_cnt == NUM_CHUNKS));
    chk("busy", MSG_SIZE'(bus.busy), MSG_SIZE'(exp_cnt != NUM_CHUNKS));
  endtask

  task automatic bubble();
    bus.chunk_valid = 1'b0;
    bus.chunk_in    = 16'(($urandom));
    step();
    chk("bubble_slice_valid", MSG_SIZE'(bus.slice_valid), 0);
    chk("bubble_cnt", MSG_SIZE'(bus.chunk_count), MSG_SIZE'(exp_cnt));
  endtask

  initial begin
    logic [KEY_SIZE-1:0] rc [NUM_CHUNKS];
    logic [KEY_SIZE-1:0] rk [NUM_CHUNKS];
    logic [MSG_SIZE-1:0] gap_cipher;
    checks = 0;
    errors = 0;
    exp_cipher = '0;
    exp_cnt = 0;
    bus.start = 1'b0;
    bus.chunk_valid = 1'b0;
    bus.chunk_in = '0;
    bus.key_in = '0;
    rst_n = 1'b0;
    #12;
    chk("rst_busy", MSG_SIZE'(bus.busy), 0);
    chk("rst_done", MSG_SIZE'(bus.done), 0);
    chk("rst_slice_valid", MSG_SIZE'(bus.slice_valid), 0);
    chk("rst_slice_out", MSG_SIZE'(bus.slice_out), 0);
    chk("rst_cnt", MSG_SIZE'(bus.chunk_count), 0);
    chk("rst_cipher", bus.cipher_out, '0);
    rst_n = 1'b1;
    step();

    // Identity key: ciphertext is the plain chunk sequence
    do_start();
    for (int i = 1; i <= NUM_CHUNKS; i++) feed(16'(i), 16'h0000);
    chk("t1_cipher", bus.cipher_out,
        240'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A_000B_000C_000D_000E_000F);
    step();
    chk("t1_done_cleared", MSG_SIZE'(bus.done), 0);
    chk("t1_busy_after", MSG_SIZE'(bus.busy), 0);

    // All-ones key over 0xA5A5
    do_start();
    for (int i = 0; i < NUM_CHUNKS; i++) feed(16'hA5A5, 16'hFFFF);
    chk("t2_cipher", bus.cipher_out, {15{16'h5A5A}});
    step();

    // Random data with bubbles, then the same data back to back
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      rc[i] = 16'($urandom);
      rk[i] = 16'($urandom);
    end
    do_start();
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      feed(rc[i], rk[i]);
      if (i < NUM_CHUNKS - 1) bubble();
    end
    chk("t3_gap_cipher", bus.cipher_out, exp_cipher);
    gap_cipher = bus.cipher_out;
    step();
    do_start();
    for (int i = 0; i < NUM_CHUNKS; i++) feed(rc[i], rk[i]);
    chk("t3_b2b_vs_gap", bus.cipher_out, gap_cipher);
    step();

    // Abort: start coincident with a valid chunk drops it
    do_start();
    for (int i = 0; i < 7; i++) feed(16'hDEAD + 16'(i), 16'h1234);
    bus.start = 1'b1;
    bus.chunk_valid = 1'b1;
    bus.chunk_in = 16'hBEEF;
    step();
    bus.start = 1'b0;
    bus.chunk_valid = 1'b0;
    exp_cipher = '0;
    exp_cnt = 0;
    chk("abort_cnt", MSG_SIZE'(bus.chunk_count), 0);
    chk("abort_cipher", bus.cipher_out, '0);
    chk("abort_slice_valid", MSG_SIZE'(bus.slice_valid), 0);
    chk("abort_busy", MSG_SIZE'(bus.busy), 1);
    for (int i = 0; i < NUM_CHUNKS; i++) feed(16'h0100 * 16'(i) + 16'h0011, 16'h0F0F);
    chk("abort_cipher_final", bus.cipher_out, exp_cipher);
    held_cipher = exp_cipher;

    // Idle hold after done
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_cipher", bus.cipher_out, held_cipher);
      chk("hold_cnt", MSG_SIZE'(bus.chunk_count), MSG_SIZE'(NUM_CHUNKS));
      chk("hold_done", MSG_SIZE'(bus.done), 0);
    end

    // Asynchronous reset mid-message
    do_start();
    for (int i = 0; i < 9; i++) feed(16'h7700 + 16'(i), 16'h00FF);
    bus.chunk_valid = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_cipher", bus.cipher_out, '0);
    chk("arst_cnt", MSG_SIZE'(bus.chunk_count), 0);
    chk("arst_busy", MSG_SIZE'(bus.busy), 0);
    chk("arst_slice_out", MSG_SIZE'(bus.slice_out), 0);
    chk("arst_slice_valid", MSG_SIZE'(bus.slice_valid), 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.chunk_valid = 1'b1;
      bus.chunk_in = 16'h1111 * 16'(i + 1);
      step();
      chk("idle_slice_valid", MSG_SIZE'(bus.slice_valid), 0);
      chk("idle_cnt", MSG_SIZE'(bus.chunk_count), 0);
      chk("idle_done", MSG_SIZE'(bus.done), 0);
      chk("idle_cipher", bus.cipher_out, '0);
    end
    bus.chunk_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
